// File: rtl/service_record_scheduler_pkg.sv
// Shared readout package for the FE-I4 service-record scheduler.
// Holds SR word layout, sizing constants, state encoding and a word packer.
package service_record_scheduler_pkg;

  localparam int NCODES = 32;
  localparam int CNT_W  = 10;
  localparam int MAX_SR = 4;

  localparam int HDR_W  = 8;
  localparam int CODE_W = 6;
  localparam int WORD_W = HDR_W + CODE_W + CNT_W;
  localparam int IDX_W  = $clog2(NCODES);
  localparam int EMIT_W = $clog2(MAX_SR + 1);

  localparam logic [HDR_W-1:0] SR_HDR  = 8'hEF;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_SELECT  = 2'd2;
  localparam logic [1:0] S_PRESENT = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = S_IDLE,
    ARMED   = S_ARMED,
    SELECT  = S_SELECT,
    PRESENT = S_PRESENT
  } state_e;

  function automatic logic [WORD_W-1:0] sr_pack(
    input logic [CODE_W-1:0] code,
    input logic [CNT_W-1:0]  cnt
  );
    return {SR_HDR, code, cnt};
  endfunction

endpackage

// File: rtl/service_record_scheduler_if.sv
// SR word stream interface: SrWord/SrValid from the scheduler, SrReady back.
// master = scheduler side, slave = readout consumer side.
interface service_record_scheduler_if;
  import service_record_scheduler_pkg::*;

  logic [WORD_W-1:0] SrWord;
  logic              SrValid;
  logic              SrReady;

  modport master (
    output SrWord,
    output SrValid,
    input  SrReady
  );

  modport slave (
    input  SrWord,
    input  SrValid,
    output SrReady
  );

endinterface

// File: rtl/service_record_scheduler_sr_counter_bank.sv
// Per-code saturating SR event counters with sticky saturation flags.
// Ports: event_i pulses, sub_* subtract-on-accept, cnt_o/sat_o/pend_o state.
module sr_counter_bank
  import service_record_scheduler_pkg::*;
(
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [NCODES-1:0]             event_i,
  input  logic                          sub_en_i,
  input  logic [CODE_W-1:0]             sub_code_i,
  input  logic [CNT_W-1:0]              sub_val_i,
  output logic [NCODES-1:0][CNT_W-1:0]  cnt_o,
  output logic [NCODES-1:0]             sat_o,
  output logic [NCODES-1:0]             pend_o
);

  logic [NCODES-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NCODES-1:0]            sat_q, sat_d;

  // The snapshot never exceeds the live count (counts only grow between
  // snap and accept), so the subtract cannot underflow. Events on the
  // accepted code in the same cycle are added back on top.
  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    for (int i = 0; i < NCODES; i++) begin
      if (sub_en_i && (sub_code_i == CODE_W'(i))) begin
        cnt_d[i] = cnt_q[i] - sub_val_i + CNT_W'(event_i[i]);
        sat_d[i] = 1'b0;
      end else if (event_i[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          sat_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      sat_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  always_comb begin
    pend_o = '0;
    for (int i = 0; i < NCODES; i++) begin
      pend_o[i] = |cnt_q[i];
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/service_record_scheduler.sv
// Service-record scheduler: counts SR events, requests header flagging,
// then emits up to MAX_SR SR words per flagged header over the sr stream.
module service_record_scheduler
  import service_record_scheduler_pkg::*;
(
  input  logic                        Clk,
  input  logic                        Reset_b,
  input  logic [NCODES-1:0]           SrEvent,
  input  logic                        HeaderStrobe,
  input  logic                        ErrorReq,
  output logic                        ServReq,
  output logic                        Busy,
  output logic [NCODES-1:0]           CntSat,
  service_record_scheduler_if.master  sr
);

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                valid_q, valid_d;
  logic                sreq_q, sreq_d;
  logic [EMIT_W-1:0]   emit_q, emit_d;

  logic [NCODES-1:0][CNT_W-1:0] cnt;
  logic [NCODES-1:0]            pend;
  logic                         fire;
  logic                         sel_any;
  logic [IDX_W-1:0]             sel_idx;

  assign fire = valid_q && sr.SrReady;

  // The presented word carries the latched code and snapshot.
  sr_counter_bank u_bank (
    .clk_i      (Clk),
    .rst_n_i    (Reset_b),
    .event_i    (SrEvent),
    .sub_en_i   (fire),
    .sub_code_i (word_q[CNT_W +: CODE_W]),
    .sub_val_i  (word_q[CNT_W-1:0]),
    .cnt_o      (cnt),
    .sat_o      (CntSat),
    .pend_o     (pend)
  );

  // Lowest pending index wins: scan downward, last hit sticks.
  always_comb begin
    sel_any = 1'b0;
    sel_idx = '0;
    for (int i = NCODES - 1; i >= 0; i--) begin
      if (pend[i]) begin
        sel_any = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    emit_d  = emit_q;
    unique case (state_q)
      IDLE: begin
        if ((|pend) && !ErrorReq) state_d = ARMED;
      end
      ARMED: begin
        // A header under ErrorReq leaves unflagged, so keep waiting.
        if (HeaderStrobe && !ErrorReq) begin
          state_d = SELECT;
          emit_d  = '0;
        end
      end
      SELECT: begin
        if (sel_any) begin
          state_d = PRESENT;
          word_d  = sr_pack(CODE_W'(sel_idx), cnt[sel_idx]);
        end else begin
          state_d = IDLE;
        end
      end
      PRESENT: begin
        if (fire) begin
          emit_d  = emit_q + 1'b1;
          state_d = (emit_d == EMIT_W'(MAX_SR)) ? IDLE : SELECT;
        end
      end
      default: state_d = IDLE;
    endcase
    sreq_d  = (state_d == ARMED);
    valid_d = (state_d == PRESENT);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_b) begin
      state_q <= IDLE;
      word_q  <= '0;
      valid_q <= 1'b0;
      sreq_q  <= 1'b0;
      emit_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      sreq_q  <= sreq_d;
      emit_q  <= emit_d;
    end
  end

  assign ServReq    = sreq_q;
  assign Busy       = (state_q != IDLE);
  assign sr.SrWord  = word_q;
  assign sr.SrValid = valid_q;

endmodule

// File: tb/tb_service_record_scheduler.sv
// Directed table-driven bench for service_record_scheduler.
// Table rows: inputs for one cycle plus expected outputs after the edge.
module tb_service_record_scheduler;
  import service_record_scheduler_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset_b;
  logic [31:0] SrEvent;
  logic        HeaderStrobe;
  logic        ErrorReq;
  logic        ServReq;
  logic        Busy;
  logic [31:0] CntSat;

  service_record_scheduler_if sr_bus ();

  service_record_scheduler dut (
    .Clk          (Clk),
    .Reset_b      (Reset_b),
    .SrEvent      (SrEvent),
    .HeaderStrobe (HeaderStrobe),
    .ErrorReq     (ErrorReq),
    .ServReq      (ServReq),
    .Busy         (Busy),
    .CntSat       (CntSat),
    .sr           (sr_bus)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [31:0] ev;
    logic        hs;
    logic        err;
    logic        rdy;
    logic        sr;
    logic        v;
    logic        busy;
    logic [23:0] word;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic [31:0] ev,
                     input logic hs, input logic err, input logic rdy,
                     input logic s, input logic v, input logic b,
                     input logic [23:0] w);
    vec_t r;
    r.name = n; r.ev = ev; r.hs = hs; r.err = err; r.rdy = rdy;
    r.sr = s; r.v = v; r.busy = b; r.word = w;
    vecs.push_back(r);
  endtask

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ev, input logic hs,
                       input logic err, input logic rdy);
    SrEvent = ev;
    HeaderStrobe = hs;
    ErrorReq = err;
    sr_bus.SrReady = rdy;
  endtask

  localparam logic [31:0] B0  = 32'h1 << 0;
  localparam logic [31:0] B2  = 32'h1 << 2;
  localparam logic [31:0] B3  = 32'h1 << 3;
  localparam logic [31:0] B5  = 32'h1 << 5;
  localparam logic [31:0] B6  = 32'h1 << 6;
  localparam logic [31:0] B8  = 32'h1 << 8;
  localparam logic [31:0] PRI = (32'h1 << 1) | (32'h1 << 4) | (32'h1 << 7)
                              | (32'h1 << 9) | (32'h1 << 12);

  initial begin
    // ---- reset with events present ----
    Reset_b = 1'b0;
    drive(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      SrEvent = (i % 2 == 0) ? B3 : 32'h0;
      tick();
    end
    chk("rst.servreq", ServReq, 0);
    chk("rst.valid", sr_bus.SrValid, 0);
    chk("rst.word", sr_bus.SrWord, 0);
    chk("rst.busy", Busy, 0);
    chk("rst.cntsat", CntSat, 0);
    Reset_b = 1'b1;
    drive(0, 0, 0, 0);
    tick();
    tick();
    chk("rst.cnt3_zero_busy", Busy, 0);
    chk("rst.cnt3_zero_sreq", ServReq, 0);

    // ---- vector table ----
    //       name      ev   hs err rdy sr v  busy word
    add("basic0",  B5,  0, 0, 0, 0, 0, 0, 24'h0);
    add("basic1",  B5,  0, 0, 0, 1, 0, 1, 24'h0);
    add("basic2",  B5,  0, 0, 0, 1, 0, 1, 24'h0);
    add("basic3",  0,   1, 0, 0, 0, 0, 1, 24'h0);
    add("basic4",  0,   0, 0, 0, 0, 1, 1, 24'hEF1403);
    add("basic5",  0,   0, 0, 1, 0, 0, 1, 24'h0);
    add("basic6",  0,   0, 0, 0, 0, 0, 0, 24'h0);
    add("basic7",  0,   0, 0, 0, 0, 0, 0, 24'h0);

    add("err0",    B2,  0, 0, 0, 0, 0, 0, 24'h0);
    add("err1",    0,   0, 0, 0, 1, 0, 1, 24'h0);
    add("err2",    0,   1, 1, 0, 1, 0, 1, 24'h0);
    add("err3",    0,   0, 1, 0, 1, 0, 1, 24'h0);
    add("err4",    0,   1, 0, 0, 0, 0, 1, 24'h0);
    add("err5",    0,   0, 0, 0, 0, 1, 1, 24'hEF0801);
    add("err6",    0,   0, 0, 1, 0, 0, 1, 24'h0);
    add("err7",    0,   0, 0, 0, 0, 0, 0, 24'h0);

    add("pri0",    PRI, 0, 0, 0, 0, 0, 0, 24'h0);
    add("pri1",    0,   0, 0, 0, 1, 0, 1, 24'h0);
    add("pri2",    0,   1, 0, 0, 0, 0, 1, 24'h0);
    add("pri3",    0,   0, 0, 0, 0, 1, 1, 24'hEF0401);
    add("pri4",    0,   0, 0, 1, 0, 0, 1, 24'h0);
    add("pri5",    0,   0, 0, 0, 0, 1, 1, 24'hEF1001);
    add("pri6",    0,   0, 0, 1, 0, 0, 1, 24'h0);
    add("pri7",    0,   0, 0, 0, 0, 1, 1, 24'hEF1C01);
    add("pri8",    0,   0, 0, 1, 0, 0, 1, 24'h0);
    add("pri9",    0,   0, 0, 0, 0, 1, 1, 24'hEF2401);
    add("pri10",   0,   0, 0, 1, 0, 0, 0, 24'h0);
    add("pri11",   0,   0, 0, 0, 1, 0, 1, 24'h0);
    add("pri12",   0,   1, 0, 0, 0, 0, 1, 24'h0);
    add("pri13",   0,   0, 0, 0, 0, 1, 1, 24'hEF3001);
    add("pri14",   0,   0, 0, 1, 0, 0, 1, 24'h0);
    add("pri15",   0,   0, 0, 0, 0, 0, 0, 24'h0);

    add("bp0",     B0,  0, 0, 0, 0, 0, 0, 24'h0);
    add("bp1",     B0,  0, 0, 0, 1, 0, 1, 24'h0);
    add("bp2",     0,   1, 0, 0, 0, 0, 1, 24'h0);
    add("bp3",     0,   0, 0, 0, 0, 1, 1, 24'hEF0002);
    add("bp4",     B0,  0, 0, 0, 0, 1, 1, 24'hEF0002);
    add("bp5",     0,   0, 0, 0, 0, 1, 1, 24'hEF0002);
    add("bp6",     B0,  0, 0, 0, 0, 1, 1, 24'hEF0002);
    add("bp7",     0,   0, 0, 0, 0, 1, 1, 24'hEF0002);
    add("bp8",     0,   0, 0, 0, 0, 1, 1, 24'hEF0002);
    add("bp9",     0,   0, 0, 1, 0, 0, 1, 24'h0);
    add("bp10",    0,   0, 0, 0, 0, 1, 1, 24'hEF0002);
    add("bp11",    B0,  0, 0, 1, 0, 0, 1, 24'h0);
    add("bp12",    0,   0, 0, 0, 0, 1, 1, 24'hEF0001);
    add("bp13",    0,   0, 0, 1, 0, 0, 1, 24'h0);
    add("bp14",    0,   0, 0, 0, 0, 0, 0, 24'h0);

    foreach (vecs[k]) begin
      drive(vecs[k].ev, vecs[k].hs, vecs[k].err, vecs[k].rdy);
      tick();
      chk({vecs[k].name, ".servreq"}, ServReq, vecs[k].sr);
      chk({vecs[k].name, ".valid"}, sr_bus.SrValid, vecs[k].v);
      chk({vecs[k].name, ".busy"}, Busy, vecs[k].busy);
      chk({vecs[k].name, ".cntsat"}, CntSat, 0);
      if (vecs[k].v)
        chk({vecs[k].name, ".word"}, sr_bus.SrWord, vecs[k].word);
    end
    drive(0, 0, 0, 0);

    // ---- saturation on code 8 ----
    for (int k = 1; k <= 1025; k++) begin
      drive(B8, 0, 0, 0);
      tick();
      if (k == 1023) chk("sat.not_yet", CntSat, 0);
    end
    chk("sat.flag", CntSat, B8);
    chk("sat.servreq", ServReq, 1);
    drive(0, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    tick();
    chk("sat.valid", sr_bus.SrValid, 1);
    chk("sat.word", sr_bus.SrWord, 24'hEF23FF);
    chk("sat.flag_held", CntSat, B8);
    drive(0, 0, 0, 1);
    tick();
    chk("sat.flag_clr", CntSat, 0);
    chk("sat.valid_drop", sr_bus.SrValid, 0);
    drive(0, 0, 0, 0);
    tick();
    chk("sat.idle", Busy, 0);

    // ---- reset mid-emission drops the word and the counts ----
    drive(B6, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    tick();
    drive(0, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    tick();
    chk("midrst.valid", sr_bus.SrValid, 1);
    chk("midrst.word", sr_bus.SrWord, 24'hEF1801);
    Reset_b = 1'b0;
    tick();
    chk("midrst.valid0", sr_bus.SrValid, 0);
    chk("midrst.word0", sr_bus.SrWord, 0);
    chk("midrst.busy0", Busy, 0);
    Reset_b = 1'b1;
    tick();
    tick();
    chk("midrst.lost_busy", Busy, 0);
    chk("midrst.lost_sreq", ServReq, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
